// File: rtl/sirv_qspi_tl_flash_rdbridge.sv
// Byte-wide TileLink slave that turns a Get into one flash-link read command
// and streams the returned bytes back as 8-bit AccessAckData beats. Anything
// else is answered with error beats so the upstream beat counter completes.
module sirv_qspi_tl_flash_rdbridge #(
    parameter int MAX_SIZE = 2,
    parameter int ADDR_W   = 30
) (
    input  logic              clock,
    input  logic              reset,
    output logic              io_in_a_ready,
    input  logic              io_in_a_valid,
    input  logic [2:0]        io_in_a_bits_opcode,
    input  logic [2:0]        io_in_a_bits_size,
    input  logic [1:0]        io_in_a_bits_source,
    input  logic [ADDR_W-1:0] io_in_a_bits_address,
    input  logic              io_in_a_bits_mask,
    input  logic              io_in_d_ready,
    output logic              io_in_d_valid,
    output logic [2:0]        io_in_d_bits_opcode,
    output logic [2:0]        io_in_d_bits_size,
    output logic [1:0]        io_in_d_bits_source,
    output logic              io_in_d_bits_addr_lo,
    output logic [7:0]        io_in_d_bits_data,
    output logic              io_in_d_bits_error,
    output logic              io_link_cmd_valid,
    input  logic              io_link_cmd_ready,
    output logic [ADDR_W-1:0] io_link_cmd_addr,
    output logic [2:0]        io_link_cmd_len,
    input  logic              io_link_rx_valid,
    output logic              io_link_rx_ready,
    input  logic [7:0]        io_link_rx_data
);

    typedef enum logic [1:0] {IDLE, CMD, DATA, ERR} state_t;

    state_t            state, state_nxt;
    logic [2:0]        op_q;
    logic [2:0]        size_q;
    logic [1:0]        src_q;
    logic [ADDR_W-1:0] addr_q;
    logic [2:0]        beat;
    logic              a_fire, d_fire, cmd_fire;
    logic              req_ok, size_ok;
    logic [2:0]        last_beat;
    logic              unused_mask;

    // Byte lanes are implied by the byte-wide bus, so the mask carries nothing.
    assign unused_mask = io_in_a_bits_mask;

    assign a_fire   = io_in_a_valid && io_in_a_ready;
    assign d_fire   = io_in_d_valid && io_in_d_ready;
    assign cmd_fire = io_link_cmd_valid && io_link_cmd_ready;
    assign req_ok   = (io_in_a_bits_opcode == 3'd4) && (io_in_a_bits_size <= 3'(MAX_SIZE));

    // Oversized requests collapse to a single error beat.
    assign size_ok   = size_q <= 3'(MAX_SIZE);
    assign last_beat = size_ok ? (3'd1 << size_q) - 3'd1 : 3'd0;

    assign io_in_d_bits_size    = size_q;
    assign io_in_d_bits_source  = src_q;
    assign io_in_d_bits_addr_lo = addr_q[0];
    assign io_link_cmd_addr     = addr_q;
    assign io_link_cmd_len      = last_beat;

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state decode; the last beat always lands in IDLE, giving one bubble before the next A.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (a_fire) state_nxt = req_ok ? CMD : ERR;
            CMD:      if (cmd_fire) state_nxt = DATA;
            DATA,
            ERR:      if (d_fire && beat == last_beat) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // Output decode; DATA is a zero-latency pass-through between flash and D.
    always_comb begin
        io_in_a_ready       = 1'b0;
        io_in_d_valid       = 1'b0;
        io_in_d_bits_opcode = 3'd0;
        io_in_d_bits_data   = 8'h00;
        io_in_d_bits_error  = 1'b0;
        io_link_cmd_valid   = 1'b0;
        io_link_rx_ready    = 1'b0;
        case (state)
            IDLE: io_in_a_ready = 1'b1;
            CMD:  io_link_cmd_valid = 1'b1;
            DATA: begin
                io_link_rx_ready    = io_in_d_ready;
                io_in_d_valid       = io_link_rx_valid;
                io_in_d_bits_data   = io_link_rx_data;
                io_in_d_bits_opcode = 3'd1;
            end
            ERR: begin
                io_in_d_valid       = 1'b1;
                io_in_d_bits_error  = 1'b1;
                io_in_d_bits_opcode = (op_q == 3'd4) ? 3'd1 : 3'd0;
            end
            default: ;
        endcase
    end

    // Request capture and beat counting; the counter clears on the final beat.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            op_q   <= '0;
            size_q <= '0;
            src_q  <= '0;
            addr_q <= '0;
            beat   <= '0;
        end else begin
            if (state == IDLE && a_fire) begin
                op_q   <= io_in_a_bits_opcode;
                size_q <= io_in_a_bits_size;
                src_q  <= io_in_a_bits_source;
                addr_q <= io_in_a_bits_address;
            end
            if (state == CMD && cmd_fire)
                beat <= '0;
            else if ((state == DATA || state == ERR) && d_fire)
                beat <= (beat == last_beat) ? 3'd0 : beat + 3'd1;
        end
    end

endmodule
